tcm_dec_tmu_tree_gen: RTL and testbench



---
 rtl/tcm_dec_tmu_tree_gen_if.sv | 27 ++
 rtl/tcm_dec_tmu_tree_gen.sv | 116 +++++++++++
 tb/tb_tcm_dec_tmu_tree_gen.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/tcm_dec_tmu_tree_gen_if.sv
// Metric-set input and best-branch output bundle of the TMU add-compare-select tree.
interface tcm_dec_tmu_tree_gen_if #(
    parameter int unsigned pSYMB_M_W   = 8,
    parameter int unsigned pGROUP_NUM  = 2,
    parameter int unsigned pGROUP_SIZE = 4,
    parameter int unsigned pBM_W       = pSYMB_M_W + 2
);
    localparam int unsigned N    = pGROUP_NUM * pGROUP_SIZE;
    localparam int unsigned IdxW = $clog2(N);

    logic                     ival;
    logic [N*4*pSYMB_M_W-1:0] isymb_m;
    logic                     oval;
    logic [pBM_W-1:0]         obm;
    logic [pBM_W-1:0]         obm_delta;
    logic [IdxW-1:0]          osymb_m_idx;

    modport master (
        output ival, isymb_m,
        input  oval, obm, obm_delta, osymb_m_idx
    );

    modport slave (
        input  ival, isymb_m,
        output oval, obm, obm_delta, osymb_m_idx
    );
endinterface

// File: rtl/tcm_dec_tmu_tree_gen.sv
// Pipelined add-compare-select tree for the 4D-8PSK TCM trellis metric unit: selects the best of
// pGROUP_NUM*pGROUP_SIZE candidates and reports its margin over the runner-up.
module tcm_dec_tmu_tree_gen #(
    parameter int unsigned pSYMB_M_W   = 8,
    parameter int unsigned pGROUP_NUM  = 2,
    parameter int unsigned pGROUP_SIZE = 4,
    parameter int unsigned pBM_W       = pSYMB_M_W + 2
) (
    input  logic                  iclk,
    input  logic                  ireset,
    input  logic                  iclkena,
    tcm_dec_tmu_tree_gen_if.slave bus
);
    localparam int W    = int'(pSYMB_M_W);
    localparam int GN   = int'(pGROUP_NUM);
    localparam int GS   = int'(pGROUP_SIZE);
    localparam int N    = GN * GS;
    localparam int IdxW = $clog2(N);
    localparam int LB   = $clog2(GS);
    localparam int LD   = $clog2(GN);
    localparam int L    = 2 + LB + LD;
    localparam int NB   = 2 * N - GN;  // leaf stage plus all in-group merge levels
    localparam int ND   = 2 * GN - 1;  // dim3 stage plus all cross-group merge levels

    typedef struct packed {
        logic [pBM_W-1:0] best;
        logic [pBM_W-1:0] second;
        logic [IdxW-1:0]  idx;
        logic             has2;
    } node_t;

    // Level j of a halving tree starts right after the 2*size - 2*(size>>j) nodes before it.
    function automatic int boff(input int j);
        return 2 * N - 2 * (N >> j);
    endfunction

    function automatic int doff(input int j);
        return 2 * GN - 2 * (GN >> j);
    endfunction

    // a always holds the lower indices, so b must be strictly greater to win.
    function automatic node_t merge(input node_t a, input node_t b);
        node_t w;
        node_t l;
        node_t r;
        if (b.best > a.best) begin
            w = b;
            l = a;
        end else begin
            w = a;
            l = b;
        end
        r        = w;
        r.has2   = 1'b1;
        r.second = (w.has2 && (w.second > l.best)) ? w.second : l.best;
        return r;
    endfunction

    logic [L-1:0]         vld_q;
    node_t                b_q  [NB];
    node_t                d_q  [ND];
    logic [pSYMB_M_W-1:0] d3_q [LB+1][GN];

    always_ff @(posedge iclk) begin
        if (ireset) begin
            vld_q <= '0;
            b_q   <= '{default: '0};
            d_q   <= '{default: '0};
            d3_q  <= '{default: '0};
        end else if (iclkena) begin
            vld_q <= {vld_q[L-2:0], bus.ival};
            if (bus.ival) begin
                for (int k = 0; k < N; k++) begin
                    b_q[k].best   <= pBM_W'(bus.isymb_m[(4*k)*W +: W])
                                   + pBM_W'(bus.isymb_m[(4*k+1)*W +: W])
                                   + pBM_W'(bus.isymb_m[(4*k+2)*W +: W]);
                    b_q[k].second <= '0;
                    b_q[k].idx    <= IdxW'(k);
                    b_q[k].has2   <= 1'b0;
                end
                for (int g = 0; g < GN; g++) begin
                    d3_q[0][g] <= bus.isymb_m[(4*g*GS+3)*W +: W];
                end
            end
            for (int j = 1; j <= LB; j++) begin
                if (vld_q[j-1]) begin
                    for (int i = 0; i < (N >> j); i++) begin
                        b_q[boff(j)+i] <= merge(b_q[boff(j-1)+2*i], b_q[boff(j-1)+2*i+1]);
                    end
                    d3_q[j] <= d3_q[j-1];
                end
            end
            // dim3 is shared by the whole group, so adding it to both keeps the margin intact.
            if (vld_q[LB]) begin
                for (int g = 0; g < GN; g++) begin
                    d_q[g].best   <= b_q[boff(LB)+g].best + pBM_W'(d3_q[LB][g]);
                    d_q[g].second <= b_q[boff(LB)+g].second + pBM_W'(d3_q[LB][g]);
                    d_q[g].idx    <= b_q[boff(LB)+g].idx;
                    d_q[g].has2   <= b_q[boff(LB)+g].has2;
                end
            end
            for (int j = 1; j <= LD; j++) begin
                if (vld_q[LB+j]) begin
                    for (int i = 0; i < (GN >> j); i++) begin
                        d_q[doff(j)+i] <= merge(d_q[doff(j-1)+2*i], d_q[doff(j-1)+2*i+1]);
                    end
                end
            end
        end
    end

    assign bus.oval        = vld_q[L-1];
    assign bus.obm         = d_q[ND-1].best;
    assign bus.obm_delta   = d_q[ND-1].best - d_q[ND-1].second;
    assign bus.osymb_m_idx = d_q[ND-1].idx;
endmodule

// File: tb/tb_tcm_dec_tmu_tree_gen.sv
// Bench for the TMU ACS tree: a 2x4 and a 1x8 instance share stimulus and are checked against a
// sort-based reference of best, runner-up and index.
module tb_tcm_dec_tmu_tree_gen;
    localparam int W  = 8;
    localparam int N  = 8;
    localparam int MW = N * 4 * W;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    always #5 clk = ~clk;

    tcm_dec_tmu_tree_gen_if #(.pSYMB_M_W(W), .pGROUP_NUM(2), .pGROUP_SIZE(4)) ifa ();
    tcm_dec_tmu_tree_gen_if #(.pSYMB_M_W(W), .pGROUP_NUM(1), .pGROUP_SIZE(8)) ifb ();

    tcm_dec_tmu_tree_gen #(.pSYMB_M_W(W), .pGROUP_NUM(2), .pGROUP_SIZE(4)) dut_a (
        .iclk(clk), .iclkena(ena), .ireset(rst), .bus(ifa)
    );
    tcm_dec_tmu_tree_gen #(.pSYMB_M_W(W), .pGROUP_NUM(1), .pGROUP_SIZE(8)) dut_b (
        .iclk(clk), .iclkena(ena), .ireset(rst), .bus(ifb)
    );

    typedef struct {
        logic [9:0] bm;
        logic [9:0] dl;
        logic [2:0] ix;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t qa[$];
    exp_t qb[$];

    // Full metric = own dims 0..2 plus dim3 of the group's first candidate.
    function automatic exp_t model(input logic [MW-1:0] m, input int gs);
        int   full[N];
        int   best;
        int   second;
        int   idx;
        exp_t e;
        for (int k = 0; k < N; k++) begin
            full[k] = int'(m[(4*k)*W +: W]) + int'(m[(4*k+1)*W +: W]) + int'(m[(4*k+2)*W +: W])
                    + int'(m[(4*((k/gs)*gs)+3)*W +: W]);
        end
        best = -1;
        idx  = 0;
        for (int k = 0; k < N; k++) if (full[k] > best) begin best = full[k]; idx = k; end
        second = -1;
        for (int k = 0; k < N; k++) if (k != idx && full[k] > second) second = full[k];
        e.bm = 10'(best);
        e.dl = 10'(best - second);
        e.ix = 3'(idx);
        return e;
    endfunction

    function automatic logic [MW-1:0] rand_vec();
        logic [MW-1:0] m;
        int            mx;
        mx = ($urandom_range(0, 1) == 1) ? 255 : 3;
        for (int b = 0; b < 4 * N; b++) m[b*W +: W] = 8'($urandom_range(0, mx));
        return m;
    endfunction

    task automatic tick(input logic e, input logic v, input logic [MW-1:0] m);
        ena         = e;
        ifa.ival    = v;
        ifb.ival    = v;
        ifa.isymb_m = m;
        ifb.isymb_m = m;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1'b1, 1'b1, rand_vec());
        tick(1'b1, 1'b1, rand_vec());
        checks += 8;
        if (ifa.oval !== 1'b0) begin errors++; $display("FAIL reset oval_a got %b want 0", ifa.oval); end
        if (ifa.obm !== 10'd0) begin errors++; $display("FAIL reset obm_a got %0d want 0", ifa.obm); end
        if (ifa.obm_delta !== 10'd0) begin errors++; $display("FAIL reset delta_a got %0d want 0", ifa.obm_delta); end
        if (ifa.osymb_m_idx !== 3'd0) begin errors++; $display("FAIL reset idx_a got %0d want 0", ifa.osymb_m_idx); end
        if (ifb.oval !== 1'b0) begin errors++; $display("FAIL reset oval_b got %b want 0", ifb.oval); end
        if (ifb.obm !== 10'd0) begin errors++; $display("FAIL reset obm_b got %0d want 0", ifb.obm); end
        if (ifb.obm_delta !== 10'd0) begin errors++; $display("FAIL reset delta_b got %0d want 0", ifb.obm_delta); end
        if (ifb.osymb_m_idx !== 3'd0) begin errors++; $display("FAIL reset idx_b got %0d want 0", ifb.osymb_m_idx); end
        rst = 1'b0;
    endtask

    // One set into an idle pipe: oval must appear exactly once, after the 4th following edge.
    task automatic test_single(input string name, input logic [MW-1:0] m);
        exp_t ea;
        exp_t eb;
        int   fa = -1;
        int   fb = -1;
        int   na = 0;
        int   nb = 0;
        ea = model(m, 4);
        eb = model(m, 8);
        tick(1'b1, 1'b1, m);
        for (int c = 1; c <= 12; c++) begin
            tick(1'b1, 1'b0, '0);
            if (ifa.oval === 1'b1) begin
                na++;
                if (fa < 0) begin
                    fa = c;
                    checks += 3;
                    if (ifa.obm !== ea.bm) begin errors++; $display("FAIL %s obm_a got %0d want %0d", name, ifa.obm, ea.bm); end
                    if (ifa.obm_delta !== ea.dl) begin errors++; $display("FAIL %s delta_a got %0d want %0d", name, ifa.obm_delta, ea.dl); end
                    if (ifa.osymb_m_idx !== ea.ix) begin errors++; $display("FAIL %s idx_a got %0d want %0d", name, ifa.osymb_m_idx, ea.ix); end
                end
            end
            if (ifb.oval === 1'b1) begin
                nb++;
                if (fb < 0) begin
                    fb = c;
                    checks += 3;
                    if (ifb.obm !== eb.bm) begin errors++; $display("FAIL %s obm_b got %0d want %0d", name, ifb.obm, eb.bm); end
                    if (ifb.obm_delta !== eb.dl) begin errors++; $display("FAIL %s delta_b got %0d want %0d", name, ifb.obm_delta, eb.dl); end
                    if (ifb.osymb_m_idx !== eb.ix) begin errors++; $display("FAIL %s idx_b got %0d want %0d", name, ifb.osymb_m_idx, eb.ix); end
                end
            end
        end
        checks += 4;
        if (fa != 4) begin errors++; $display("FAIL %s latency_a got %0d want 4", name, fa); end
        if (fb != 4) begin errors++; $display("FAIL %s latency_b got %0d want 4", name, fb); end
        if (na != 1) begin errors++; $display("FAIL %s count_a got %0d want 1", name, na); end
        if (nb != 1) begin errors++; $display("FAIL %s count_b got %0d want 1", name, nb); end
    endtask

    task automatic test_directed();
        logic [MW-1:0] m;
        m = '0;
        for (int d = 0; d < 4; d++) m[(4*5+d)*W +: W] = 8'd10;
        test_single("lone_cand5", m);
        m = '0;
        for (int k = 0; k < N; k++) begin
            for (int d = 0; d < 3; d++) m[(4*k+d)*W +: W] = 8'd7;
            m[(4*k+3)*W +: W] = 8'd3;
        end
        test_single("all_tie", m);
        m = '0;
        m[(4*1)*W +: W] = 8'd10; m[(4*1+1)*W +: W] = 8'd10; m[(4*1+2)*W +: W] = 8'd10;
        m[(4*2)*W +: W] = 8'd10; m[(4*2+1)*W +: W] = 8'd10; m[(4*2+2)*W +: W] = 8'd8;
        m[(4*4)*W +: W] = 8'd10; m[(4*4+1)*W +: W] = 8'd10; m[(4*4+3)*W +: W] = 8'd9;
        test_single("cross_runner_up", m);
        m = '1;
        test_single("all_max", m);
    endtask

    task automatic test_stream();
        logic [MW-1:0] m;
        logic          e;
        logic          v;
        exp_t          x;
        int            acc  = 0;
        int            outa = 0;
        int            outb = 0;
        qa.delete();
        qb.delete();
        for (int cyc = 0; cyc < 600 && (acc < 20 || qa.size() > 0 || qb.size() > 0); cyc++) begin
            e = 1'($urandom_range(0, 1));
            v = (acc < 20);
            m = rand_vec();
            tick(e, v, m);
            if (e && v) begin
                qa.push_back(model(m, 4));
                qb.push_back(model(m, 8));
                acc++;
            end
            if (e && ifa.oval === 1'b1) begin
                outa++;
                checks++;
                if (qa.size() == 0) begin
                    errors++; $display("FAIL stream_a extra output got obm %0d want none", ifa.obm);
                end else begin
                    x = qa.pop_front();
                    if (ifa.obm !== x.bm || ifa.obm_delta !== x.dl || ifa.osymb_m_idx !== x.ix) begin
                        errors++;
                        $display("FAIL stream_a got %0d/%0d/%0d want %0d/%0d/%0d", ifa.obm,
                                 ifa.obm_delta, ifa.osymb_m_idx, x.bm, x.dl, x.ix);
                    end
                end
            end
            if (e && ifb.oval === 1'b1) begin
                outb++;
                checks++;
                if (qb.size() == 0) begin
                    errors++; $display("FAIL stream_b extra output got obm %0d want none", ifb.obm);
                end else begin
                    x = qb.pop_front();
                    if (ifb.obm !== x.bm || ifb.obm_delta !== x.dl || ifb.osymb_m_idx !== x.ix) begin
                        errors++;
                        $display("FAIL stream_b got %0d/%0d/%0d want %0d/%0d/%0d", ifb.obm,
                                 ifb.obm_delta, ifb.osymb_m_idx, x.bm, x.dl, x.ix);
                    end
                end
            end
        end
        checks += 2;
        if (outa != 20) begin errors++; $display("FAIL stream_count_a got %0d want 20", outa); end
        if (outb != 20) begin errors++; $display("FAIL stream_count_b got %0d want 20", outb); end
    endtask

    task automatic test_reset_in_flight();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, rand_vec());
        rst = 1'b1;
        tick(1'b0, 1'b1, rand_vec());
        checks += 4;
        if (ifa.oval !== 1'b0) begin errors++; $display("FAIL flush oval_a got %b want 0", ifa.oval); end
        if (ifa.obm !== 10'd0) begin errors++; $display("FAIL flush obm_a got %0d want 0", ifa.obm); end
        if (ifa.obm_delta !== 10'd0) begin errors++; $display("FAIL flush delta_a got %0d want 0", ifa.obm_delta); end
        if (ifb.obm !== 10'd0) begin errors++; $display("FAIL flush obm_b got %0d want 0", ifb.obm); end
        tick(1'b1, 1'b1, rand_vec());
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick(1'b1, 1'b0, '0);
            checks += 2;
            if (ifa.oval !== 1'b0) begin errors++; $display("FAIL stale_a cycle %0d oval got %b want 0", c, ifa.oval); end
            if (ifb.oval !== 1'b0) begin errors++; $display("FAIL stale_b cycle %0d oval got %b want 0", c, ifb.oval); end
        end
    endtask

    initial begin
        rst         = 1'b1;
        ena         = 1'b0;
        ifa.ival    = 1'b0;
        ifb.ival    = 1'b0;
        ifa.isymb_m = '0;
        ifb.isymb_m = '0;
        test_reset();
        test_directed();
        test_stream();
        test_reset_in_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
